// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding and grant identifiers for the I/D cache memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2,
        ARB_DRAIN   = 2'd3
    } arb_state_e;

    localparam logic GRANT_ICACHE = 1'b0;
    localparam logic GRANT_DCACHE = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the icache and dcache,
// with requester abort (drain) handling and a stalled-memory watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 20,
    parameter int unsigned LINE_W         = 128,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic              ic_we,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [LINE_W-1:0] ic_wdata,
    input  logic              ic_abort,
    output logic              ic_ready,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    input  logic              dc_abort,
    output logic              dc_ready,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id,
    output logic              timeout_err
);

    // Sized so the counter can hold TIMEOUT_CYCLES; kept at 1 bit when the watchdog is disabled.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              grant_id_q, grant_id_d;
    logic              last_grant_q, last_grant_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic ic_elig, dc_elig, pick_dc, wd_fire, cur_req, cur_abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            grant_id_q   <= GRANT_ICACHE;
            last_grant_q <= GRANT_ICACHE;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        timeout_d    = 1'b0;
        cnt_d        = (!mem_ready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

        ic_elig   = ic_req && !ic_abort;
        dc_elig   = dc_req && !dc_abort;
        // On a tie the requester that was not served last wins.
        pick_dc   = dc_elig && (!ic_elig || last_grant_q == GRANT_ICACHE);
        wd_fire   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !mem_ready;
        cur_req   = (state_q == ARB_GRANT_I) ? ic_req : dc_req;
        cur_abort = (state_q == ARB_GRANT_I) ? ic_abort : dc_abort;

        case (state_q)
            ARB_IDLE: begin
                if (ic_elig || dc_elig) begin
                    state_d     = pick_dc ? ARB_GRANT_D : ARB_GRANT_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = pick_dc ? dc_we : ic_we;
                    mem_addr_d  = pick_dc ? dc_addr : ic_addr;
                    mem_wdata_d = pick_dc ? dc_wdata : ic_wdata;
                    grant_id_d  = pick_dc ? GRANT_DCACHE : GRANT_ICACHE;
                    cnt_d       = '0;
                end
            end
            ARB_GRANT_I, ARB_GRANT_D: begin
                if (mem_ready) begin
                    state_d      = ARB_IDLE;
                    mem_req_d    = 1'b0;
                    last_grant_d = grant_id_q;
                end else if (wd_fire) begin
                    state_d      = ARB_IDLE;
                    mem_req_d    = 1'b0;
                    last_grant_d = grant_id_q;
                    timeout_d    = 1'b1;
                end else if (cur_abort || !cur_req) begin
                    // Memory cannot cancel; keep the request up and swallow the reply.
                    state_d = ARB_DRAIN;
                    cnt_d   = '0;
                end
            end
            ARB_DRAIN: begin
                if (mem_ready || wd_fire) begin
                    state_d      = ARB_IDLE;
                    mem_req_d    = 1'b0;
                    last_grant_d = grant_id_q;
                    timeout_d    = wd_fire;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != ARB_IDLE);
        ic_ready    = (state_q == ARB_GRANT_I) && mem_ready;
        dc_ready    = (state_q == ARB_GRANT_D) && mem_ready;
        ic_rdata    = ic_ready ? mem_rdata : '0;
        dc_rdata    = dc_ready ? mem_rdata : '0;
        mem_req     = mem_req_q;
        mem_we      = mem_we_q;
        mem_addr    = mem_addr_q;
        mem_wdata   = mem_wdata_q;
        grant_id    = grant_id_q;
        timeout_err = timeout_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req, ic_we, ic_abort, ic_ready;
    logic [19:0]  ic_addr;
    logic [127:0] ic_wdata, ic_rdata;
    logic         dc_req, dc_we, dc_abort, dc_ready;
    logic [19:0]  dc_addr;
    logic [127:0] dc_wdata, dc_rdata;
    logic         mem_req, mem_we, mem_ready;
    logic [19:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         busy, grant_id, timeout_err;

    mem_arbiter #(.ADDR_W(20), .LINE_W(128), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_we(ic_we), .ic_addr(ic_addr), .ic_wdata(ic_wdata),
        .ic_abort(ic_abort), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_abort(dc_abort), .dc_ready(dc_ready), .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         gid;
        logic         we;
        logic [19:0]  addr;
        logic [127:0] wdata;
    } grant_t;
    typedef struct {
        int           kind;   // 0 icache ready, 1 dcache ready, 2 watchdog
        logic [127:0] data;
    } resp_t;

    grant_t grant_q[$];
    resp_t  resp_q[$];
    int     checks = 0;
    int     errors = 0;
    logic   mem_req_prev = 1'b0;

    localparam logic [127:0] R1 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] R2 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] R3 = 128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F;
    localparam logic [127:0] W1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] W2 = 128'hBADC0FFE_E0DDF00D_12345678_9ABCDEF0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_grant(input logic gid, input logic we, input logic [19:0] addr,
                             input logic [127:0] wdata);
        grant_t g;
        g.gid = gid; g.we = we; g.addr = addr; g.wdata = wdata;
        grant_q.push_back(g);
    endtask

    task automatic exp_resp(input int kind, input logic [127:0] data);
        resp_t r;
        r.kind = kind; r.data = data;
        resp_q.push_back(r);
    endtask

    task automatic handle_resp(input int kind, input logic [127:0] data);
        resp_t r;
        if (resp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got kind %0d expected none", kind);
        end else begin
            r = resp_q.pop_front();
            chk("resp_kind", 128'(kind), 128'(r.kind));
            chk("resp_rdata", data, r.data);
        end
    endtask

    always @(negedge clk) begin
        grant_t g;
        if (mem_req === 1'b1 && mem_req_prev !== 1'b1) begin
            if (grant_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_grant: got addr %h expected none", mem_addr);
            end else begin
                g = grant_q.pop_front();
                chk("grant_id", 128'(grant_id), 128'(g.gid));
                chk("mem_we", 128'(mem_we), 128'(g.we));
                chk("mem_addr", 128'(mem_addr), 128'(g.addr));
                chk("mem_wdata", mem_wdata, g.wdata);
            end
        end
        mem_req_prev = mem_req;
        if (ic_ready === 1'b1) handle_resp(0, ic_rdata);
        else chk("ic_rdata_idle", ic_rdata, '0);
        if (dc_ready === 1'b1) handle_resp(1, dc_rdata);
        else chk("dc_rdata_idle", dc_rdata, '0);
        if (timeout_err === 1'b1) handle_resp(2, '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_pulse(input logic [127:0] data);
        mem_ready = 1'b1;
        mem_rdata = data;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ic_req = 0; ic_we = 0; ic_addr = '0; ic_wdata = '0; ic_abort = 0;
        dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0; dc_abort = 0;
        mem_ready = 0; mem_rdata = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_mem_req", 128'(mem_req), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_grant_id", 128'(grant_id), 0);
        chk("rst_mem_addr", 128'(mem_addr), 0);
        tick(); reset = 1'b0;

        // Single icache fill, memory answers 5 cycles after the grant
        tick();
        exp_grant(0, 0, 20'h00040, '0);
        ic_req = 1; ic_addr = 20'h00040;
        tick();
        @(negedge clk);
        chk("t1_mem_req", 128'(mem_req), 1);
        chk("t1_busy", 128'(busy), 1);
        repeat (4) tick();
        exp_resp(0, R1);
        mem_pulse(R1);
        ic_req = 0;
        @(negedge clk);
        chk("t1_busy_after", 128'(busy), 0);

        // Tie after reset: dcache first, one IDLE cycle, then icache; dcache re-requests
        tick();
        exp_grant(1, 1, 20'h00200, W1);
        exp_grant(0, 0, 20'h00100, '0);
        exp_grant(1, 0, 20'h00204, '0);
        ic_req = 1; ic_addr = 20'h00100;
        dc_req = 1; dc_we = 1; dc_addr = 20'h00200; dc_wdata = W1;
        tick();
        tick(); tick();
        exp_resp(1, R2);
        mem_pulse(R2);
        dc_we = 0; dc_addr = 20'h00204; dc_wdata = '0;
        @(negedge clk);
        chk("t2_idle_gap_busy", 128'(busy), 0);
        chk("t2_idle_gap_req", 128'(mem_req), 0);
        tick();
        @(negedge clk);
        chk("t2_second_tie_ic", 128'(grant_id), 0);
        tick();
        exp_resp(0, R3);
        mem_pulse(R3);
        ic_req = 0;
        tick(); tick();
        exp_resp(1, R1);
        mem_pulse(R1);
        dc_req = 0;

        // Abort during dcache grant; pending icache waits for the drain
        tick();
        exp_grant(1, 0, 20'h00300, '0);
        dc_req = 1; dc_addr = 20'h00300;
        tick();
        tick(); tick();
        exp_grant(0, 0, 20'h00400, '0);
        dc_abort = 1;
        ic_req = 1; ic_addr = 20'h00400;
        tick();
        dc_abort = 0; dc_req = 0;
        @(negedge clk);
        chk("t3_drain_req", 128'(mem_req), 1);
        tick(); tick();
        @(negedge clk);
        chk("t3_drain_hold", 128'(grant_id), 1);
        mem_pulse(R2);
        @(negedge clk);
        chk("t3_drain_done_req", 128'(mem_req), 0);
        tick();
        @(negedge clk);
        chk("t3_ic_after_drain", 128'(grant_id), 0);
        tick();
        exp_resp(0, R3);
        mem_pulse(R3);
        ic_req = 0;

        // Ready and abort in the same cycle: completion wins
        tick();
        exp_grant(1, 0, 20'h00500, '0);
        dc_req = 1; dc_addr = 20'h00500;
        tick(); tick();
        exp_resp(1, R1);
        dc_abort = 1;
        mem_pulse(R1);
        dc_abort = 0; dc_req = 0;
        @(negedge clk);
        chk("t4_no_drain_busy", 128'(busy), 0);

        // Watchdog: memory never answers
        tick();
        exp_grant(0, 0, 20'h00600, '0);
        exp_resp(2, '0);
        ic_req = 1; ic_addr = 20'h00600;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) ic_req = 0;
            @(negedge clk);
            chk($sformatf("t5_timeout_c%0d", k), 128'(timeout_err), 128'(k == 8));
            chk($sformatf("t5_mem_req_c%0d", k), 128'(mem_req), 128'(k != 8));
        end
        tick();
        @(negedge clk);
        chk("t5_timeout_pulse_end", 128'(timeout_err), 0);
        exp_grant(0, 0, 20'h00640, '0);
        ic_req = 1; ic_addr = 20'h00640;
        tick();
        exp_resp(0, R2);
        mem_pulse(R2);
        ic_req = 0;

        // Reset while in GRANT_D
        tick();
        exp_grant(1, 1, 20'h00800, W2);
        dc_req = 1; dc_we = 1; dc_addr = 20'h00800; dc_wdata = W2;
        tick();
        tick();
        reset = 1;
        tick();
        @(negedge clk);
        chk("t6_rst_mem_req", 128'(mem_req), 0);
        chk("t6_rst_mem_we", 128'(mem_we), 0);
        chk("t6_rst_mem_addr", 128'(mem_addr), 0);
        chk("t6_rst_mem_wdata", mem_wdata, '0);
        chk("t6_rst_busy", 128'(busy), 0);
        chk("t6_rst_grant_id", 128'(grant_id), 0);
        tick();
        reset = 0; dc_req = 0; dc_we = 0; dc_wdata = '0;

        // Tie after mid-transaction reset goes to the dcache again
        tick();
        exp_grant(1, 0, 20'h00900, '0);
        exp_grant(0, 0, 20'h00910, '0);
        dc_req = 1; dc_addr = 20'h00900;
        ic_req = 1; ic_addr = 20'h00910;
        tick(); tick();
        exp_resp(1, R3);
        mem_pulse(R3);
        dc_req = 0;
        tick(); tick();
        exp_resp(0, R1);
        mem_pulse(R1);
        ic_req = 0;

        repeat (3) tick();
        chk("grant_q_empty", 128'(grant_q.size()), 0);
        chk("resp_q_empty", 128'(resp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
